reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
- Integer register file with scoreboard for the RV32 datapath; sits directly upstream of the ALU and supplies its a/b operands.
- Two combinational read ports, one synchronous write port with same-cycle write-through bypass, x0 hardwired to zero.
- Per-register busy bits track in-flight producers; a stall output holds issue while an operand is pending.

Parameters:
- XLEN, 32, data width of each register and of the read/write data ports.
- NREGS, 32, number of architectural registers; must equal 2**AW.
- AW, 5, register address width.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- rs1_addr  in  AW  read port 1 address (ALU operand a).
- rs1_en  in  1  instruction uses rs1; gates hazard check only.
- rs1_data  out  XLEN  read port 1 data.
- rs2_addr  in  AW  read port 2 address (ALU operand b).
- rs2_en  in  1  instruction uses rs2; gates hazard check only.
- rs2_data  out  XLEN  read port 2 data.
- we  in  1  writeback enable.
- rd_addr  in  AW  writeback destination.
- rd_data  in  XLEN  writeback value.
- issue_valid  in  1  an instruction is issuing this cycle.
- issue_rd  in  AW  destination of the issuing instruction.
- stall  out  1  operand hazard; issue must not proceed this cycle.
- dbg_addr  in  AW  debug/testbench read address.
- dbg_data  out  XLEN  debug read data, no bypass.

Behaviour:
- Reset (rst=1 at rising edge): all registers <= 0, all busy bits <= 0. After that edge, with we=0, rs1_data=rs2_data=dbg_data=0 and stall=0. Reset overrides any we or issue_valid in the same cycle.
- Reads are combinational, zero latency. rsN_data = 0 if rsN_addr==0. Else rd_data if we && rd_addr==rsN_addr (write-through bypass). Else regs[rsN_addr].
- dbg_data = regs[dbg_addr], with x0 reading 0 and no bypass.
- Write: at the rising edge, if !rst && we && rd_addr!=0, then regs[rd_addr] <= rd_data. Writes to x0 are silently dropped.
- Busy clear: at the edge, if we && rd_addr!=0, then busy[rd_addr] <= 0.
- Busy set: at the edge, if issue_valid && !stall && issue_rd!=0, then busy[issue_rd] <= 1.
- Set and clear on the same register in the same cycle: set wins, because the new producer is outstanding.
- busy[0] is constant 0.
- hazN = rsN_en && busy[rsN_addr] && !(we && rd_addr==rsN_addr). A same-cycle writeback resolves the hazard through the bypass.
- stall = haz1 | haz2, combinational.
- issue_valid with stall=1 has no effect on busy bits.
- Writeback to a non-busy register is legal: the data is written and busy stays 0.
- rsN_en=0 never stalls, but read data is still driven.
- Reset mid-operation: all pending busy bits are discarded, and stall drops the cycle after the reset edge.

Decomposition:
- Shared package holds XLEN, AW, NREGS, and REG_ZERO (5'd0). The same package is used by the ALU and the decoder.
- Natural sub-module: reg_scoreboard, containing the busy vector, set/clear priority, and stall logic.
- The storage array and bypass muxes stay in the top module.

Test Plan:
- Reset then read: rst=1 for 1 cycle, then rs1_addr=5, rs2_addr=31 -> rs1_data=rs2_data=0 and stall=0.
- Write/readback: we=1, rd_addr=3, rd_data=32'hDEADBEEF; next cycle rs1_addr=3 -> 32'hDEADBEEF. The same cycle as the write with rs2_addr=3 -> bypass shows 32'hDEADBEEF.
- x0 protection: we=1, rd_addr=0, rd_data=32'hFFFFFFFF -> rs1_addr=0 and dbg_addr=0 read 0. Issue to rd 0 never stalls a later rs1_addr=0 read.
- Scoreboard hazard: issue_valid, issue_rd=7. Next cycle rs1_en=1, rs1_addr=7 -> stall=1. Writeback we=1, rd_addr=7, rd_data=32'h10 -> stall=0 and rs1_data=32'h10 in that same cycle; busy cleared after the edge.
- Set-wins collision: busy[9]=1, then in one cycle we=1, rd_addr=9 and issue_valid, issue_rd=9 -> next cycle rs2_en=1, rs2_addr=9 gives stall=1.
- Reset mid-flight: busy[4] and busy[12] set, then rst=1 for 1 cycle -> rs1_addr=4, rs2_addr=12 with both enables give stall=0 and data 0.

Source files
------------

// File: rtl/reg_file_sb_pkg.sv
// rtl/reg_file_sb_pkg.sv - shared RV32 register file widths and constants
package reg_file_sb_pkg;

  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int NREGS = 2 ** AW;

  localparam logic [AW-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register busy tracking and operand stall
module reg_scoreboard
  import reg_file_sb_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rs1_addr,
  input  logic          rs1_en,
  input  logic [AW-1:0] rs2_addr,
  input  logic          rs2_en,
  input  logic          we,
  input  logic [AW-1:0] rd_addr,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_rd,
  output logic          stall
);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;
  logic             haz1;
  logic             haz2;

  // A writeback in the same cycle resolves the hazard via the read bypass.
  always_comb begin
    haz1  = rs1_en && busy[rs1_addr] && !(we && rd_addr == rs1_addr);
    haz2  = rs2_en && busy[rs2_addr] && !(we && rd_addr == rs2_addr);
    stall = haz1 || haz2;
  end

  // Clear first, then set, so a new producer issuing to the register being
  // written back stays outstanding.
  always_comb begin
    busy_next = busy;
    if (we && rd_addr != REG_ZERO)
      busy_next[rd_addr] = 1'b0;
    if (issue_valid && !stall && issue_rd != REG_ZERO)
      busy_next[issue_rd] = 1'b1;
    busy_next[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst)
      busy <= '0;
    else
      busy <= busy_next;
  end

endmodule

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - RV32 integer register file with write-through bypass and scoreboard
module reg_file_sb
  import reg_file_sb_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic            rs1_en,
  output logic [XLEN-1:0] rs1_data,
  input  logic [AW-1:0]   rs2_addr,
  input  logic            rs2_en,
  output logic [XLEN-1:0] rs2_data,
  input  logic            we,
  input  logic [AW-1:0]   rd_addr,
  input  logic [XLEN-1:0] rd_data,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            stall,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else if (we && rd_addr != REG_ZERO) begin
      regs[rd_addr] <= rd_data;
    end
  end

  always_comb begin
    if (rs1_addr == REG_ZERO)
      rs1_data = '0;
    else if (we && rd_addr == rs1_addr)
      rs1_data = rd_data;
    else
      rs1_data = regs[rs1_addr];

    if (rs2_addr == REG_ZERO)
      rs2_data = '0;
    else if (we && rd_addr == rs2_addr)
      rs2_data = rd_data;
    else
      rs2_data = regs[rs2_addr];

    // Debug port observes committed state only.
    dbg_data = (dbg_addr == REG_ZERO) ? '0 : regs[dbg_addr];
  end

  reg_scoreboard u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .rs1_addr    (rs1_addr),
    .rs1_en      (rs1_en),
    .rs2_addr    (rs2_addr),
    .rs2_en      (rs2_en),
    .we          (we),
    .rd_addr     (rd_addr),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .stall       (stall)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - randomized model-checked bench for reg_file_sb
module tb_reg_file_sb;
  import reg_file_sb_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   rs1_addr, rs2_addr, rd_addr, issue_rd, dbg_addr;
  logic            rs1_en, rs2_en, we, issue_valid;
  logic [XLEN-1:0] rs1_data, rs2_data, dbg_data, rd_data;
  logic            stall;

  int checks = 0;
  int errors = 0;

  logic [XLEN-1:0] m_regs [NREGS];
  logic            m_busy [NREGS];
  logic            exp_stall;

  always #5 clk = ~clk;

  reg_file_sb dut (
    .clk         (clk),
    .rst         (rst),
    .rs1_addr    (rs1_addr),
    .rs1_en      (rs1_en),
    .rs1_data    (rs1_data),
    .rs2_addr    (rs2_addr),
    .rs2_en      (rs2_en),
    .rs2_data    (rs2_data),
    .we          (we),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .stall       (stall),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] model_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (we && rd_addr == a) return rd_data;
    return m_regs[a];
  endfunction

  function automatic logic model_stall();
    logic h1, h2;
    h1 = rs1_en && m_busy[rs1_addr] && !(we && rd_addr == rs1_addr);
    h2 = rs2_en && m_busy[rs2_addr] && !(we && rd_addr == rs2_addr);
    return h1 || h2;
  endfunction

  task automatic set_idle();
    rst = 0; we = 0; rd_addr = '0; rd_data = '0;
    issue_valid = 0; issue_rd = '0;
    rs1_en = 0; rs1_addr = '0; rs2_en = 0; rs2_addr = '0; dbg_addr = '0;
  endtask

  // Inputs are stable after a negedge; compare outputs against the model.
  task automatic settle(input bit do_check);
    #1;
    exp_stall = model_stall();
    if (do_check) begin
      chk("rs1_data", rs1_data, model_read(rs1_addr));
      chk("rs2_data", rs2_data, model_read(rs2_addr));
      chk("dbg_data", dbg_data, (dbg_addr == 0) ? '0 : m_regs[dbg_addr]);
      chk("stall", 32'(stall), 32'(exp_stall));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (we && rd_addr != 0) begin
        m_regs[rd_addr] = rd_data;
        m_busy[rd_addr] = 1'b0;
      end
      if (issue_valid && !exp_stall && issue_rd != 0)
        m_busy[issue_rd] = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < NREGS; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    set_idle();
    @(negedge clk);

    rst = 1; settle(0); tick();

    set_idle(); rs1_addr = 5'd5; rs2_addr = 5'd31; rs1_en = 1; rs2_en = 1;
    settle(1);
    chk("reset_rs1", rs1_data, 32'h0);
    chk("reset_rs2", rs2_data, 32'h0);
    chk("reset_stall", 32'(stall), 32'h0);
    tick();

    set_idle(); we = 1; rd_addr = 5'd3; rd_data = 32'hDEADBEEF; rs2_addr = 5'd3; dbg_addr = 5'd3;
    settle(1);
    chk("bypass_rs2", rs2_data, 32'hDEADBEEF);
    chk("dbg_no_bypass", dbg_data, 32'h0);
    tick();
    set_idle(); rs1_addr = 5'd3; dbg_addr = 5'd3;
    settle(1);
    chk("readback_rs1", rs1_data, 32'hDEADBEEF);
    chk("readback_dbg", dbg_data, 32'hDEADBEEF);
    tick();

    set_idle(); we = 1; rd_addr = 5'd0; rd_data = 32'hFFFFFFFF; rs1_addr = 5'd0;
    settle(1);
    chk("x0_bypass", rs1_data, 32'h0);
    tick();
    set_idle(); issue_valid = 1; issue_rd = 5'd0; dbg_addr = 5'd0;
    settle(1);
    chk("x0_dbg", dbg_data, 32'h0);
    tick();
    set_idle(); rs1_en = 1; rs1_addr = 5'd0;
    settle(1);
    chk("x0_no_stall", 32'(stall), 32'h0);
    tick();

    set_idle(); issue_valid = 1; issue_rd = 5'd7; settle(1); tick();
    set_idle(); rs1_en = 1; rs1_addr = 5'd7;
    settle(1);
    chk("haz_stall", 32'(stall), 32'h1);
    tick();
    set_idle(); rs1_en = 1; rs1_addr = 5'd7; we = 1; rd_addr = 5'd7; rd_data = 32'h10;
    settle(1);
    chk("wb_resolve_stall", 32'(stall), 32'h0);
    chk("wb_resolve_data", rs1_data, 32'h10);
    tick();
    set_idle(); rs1_en = 1; rs1_addr = 5'd7;
    settle(1);
    chk("busy_cleared", 32'(stall), 32'h0);
    tick();

    set_idle(); issue_valid = 1; issue_rd = 5'd9; settle(1); tick();
    set_idle(); we = 1; rd_addr = 5'd9; rd_data = 32'h55; issue_valid = 1; issue_rd = 5'd9;
    settle(1); tick();
    set_idle(); rs2_en = 1; rs2_addr = 5'd9;
    settle(1);
    chk("set_wins", 32'(stall), 32'h1);
    chk("set_wins_data", rs2_data, 32'h55);
    tick();
    set_idle(); we = 1; rd_addr = 5'd9; rd_data = 32'h56; settle(1); tick();

    set_idle(); issue_valid = 1; issue_rd = 5'd4; settle(1); tick();
    set_idle(); issue_valid = 1; issue_rd = 5'd12; settle(1); tick();
    set_idle(); rs1_en = 1; rs1_addr = 5'd4;
    settle(1);
    chk("pre_reset_stall", 32'(stall), 32'h1);
    rst = 1; tick();
    set_idle(); rs1_en = 1; rs1_addr = 5'd4; rs2_en = 1; rs2_addr = 5'd12; dbg_addr = 5'd3;
    settle(1);
    chk("post_reset_stall", 32'(stall), 32'h0);
    chk("post_reset_rs1", rs1_data, 32'h0);
    chk("post_reset_rs2", rs2_data, 32'h0);
    chk("post_reset_dbg", dbg_data, 32'h0);
    tick();

    for (int n = 0; n < 3000; n++) begin
      rst         = ($urandom_range(0, 99) == 0);
      we          = $urandom_range(0, 1) == 1;
      rd_addr     = AW'($urandom_range(0, 7));
      rd_data     = $urandom;
      issue_valid = $urandom_range(0, 9) < 4;
      issue_rd    = AW'($urandom_range(0, 7));
      rs1_en      = $urandom_range(0, 1) == 1;
      rs2_en      = $urandom_range(0, 1) == 1;
      rs1_addr    = AW'($urandom_range(0, 7));
      rs2_addr    = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      dbg_addr    = AW'($urandom_range(0, 7));
      settle(1);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
